vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_delay_line.sv | 25 ++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster types, the standard VGA timing sets and helpers used by the timing generator.
package vga_timing_pkg;

  // Sync/valid bundle travelling through the fetch-latency delay line (raw, active-high).
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } raster_t;

  function automatic int unsigned total(input int unsigned vis, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  // 800x600@60, 40.0 MHz pixel clock.
  localparam int unsigned SvgaHVis  = 800;
  localparam int unsigned SvgaHFp   = 40;
  localparam int unsigned SvgaHSync = 128;
  localparam int unsigned SvgaHBp   = 88;
  localparam int unsigned SvgaVVis  = 600;
  localparam int unsigned SvgaVFp   = 1;
  localparam int unsigned SvgaVSync = 4;
  localparam int unsigned SvgaVBp   = 23;

  // 640x480@60, 25.175 MHz pixel clock.
  localparam int unsigned VgaHVis  = 640;
  localparam int unsigned VgaHFp   = 16;
  localparam int unsigned VgaHSync = 96;
  localparam int unsigned VgaHBp   = 48;
  localparam int unsigned VgaVVis  = 480;
  localparam int unsigned VgaVFp   = 10;
  localparam int unsigned VgaVSync = 2;
  localparam int unsigned VgaVBp   = 33;

  // Counter widths sized for the larger of the two supported modes.
  localparam int unsigned HCntW = $clog2(total(SvgaHVis, SvgaHFp, SvgaHSync, SvgaHBp));
  localparam int unsigned VCntW = $clog2(total(SvgaVVis, SvgaVFp, SvgaVSync, SvgaVBp));

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns fetch-stage flags with pixel data.
module vga_delay_line #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: H/V counters, framebuffer fetch requests, and sync/DE outputs aligned
// with pixel data returned LATENCY clocks after each request.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS    = SvgaHVis,
  parameter int unsigned H_FP     = SvgaHFp,
  parameter int unsigned H_SYNC   = SvgaHSync,
  parameter int unsigned H_BP     = SvgaHBp,
  parameter int unsigned V_VIS    = SvgaVVis,
  parameter int unsigned V_FP     = SvgaVFp,
  parameter int unsigned V_SYNC   = SvgaVSync,
  parameter int unsigned V_BP     = SvgaVBp,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned RGB_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [HCntW-1:0] fetch_x,
  output logic [VCntW-1:0] fetch_y,
  output logic             fetch_valid,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start
);

  localparam int unsigned HTotal = total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [HCntW-1:0] HLast      = HCntW'(HTotal - 1);
  localparam logic [HCntW-1:0] HVisEnd    = HCntW'(H_VIS);
  localparam logic [HCntW-1:0] HSyncStart = HCntW'(H_VIS + H_FP);
  localparam logic [HCntW-1:0] HSyncEnd   = HCntW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VCntW-1:0] VLast      = VCntW'(VTotal - 1);
  localparam logic [VCntW-1:0] VVisEnd    = VCntW'(V_VIS);
  localparam logic [VCntW-1:0] VSyncStart = VCntW'(V_VIS + V_FP);
  localparam logic [VCntW-1:0] VSyncEnd   = VCntW'(V_VIS + V_FP + V_SYNC);

  // Losing PLL lock is treated exactly like reset.
  logic clr;
  assign clr = reset | ~enable;

  logic [HCntW-1:0] h_q, h_d;
  logic [VCntW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  raster_t raw, dly;

  always_comb begin
    raw.de = (h_q < HVisEnd) && (v_q < VVisEnd);
    raw.hs = (h_q >= HSyncStart) && (h_q < HSyncEnd);
    raw.vs = (v_q >= VSyncStart) && (v_q < VSyncEnd);
    raw.fs = (h_q == '0) && (v_q == '0);
  end

  assign fetch_x     = h_q;
  assign fetch_y     = v_q;
  assign fetch_valid = raw.de & ~clr;

  vga_delay_line #(
    .Width($bits(raster_t)),
    .Depth(LATENCY)
  ) u_delay (
    .clk_i(clk),
    .clr_i(clr),
    .d_i  (raw),
    .q_o  (dly)
  );

  logic [RGB_W-1:0] rgb_q;
  logic             hsync_q, vsync_q, de_q, fs_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= dly.de ? rgb_in : '0;
      de_q    <= dly.de;
      hsync_q <= SYNC_POL ? dly.hs : ~dly.hs;
      vsync_q <= SYNC_POL ? dly.vs : ~dly.vs;
      fs_q    <= dly.fs;
    end
  end

  assign rgb_out     = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full 800x600, two tiny rasters) checked every cycle
// against a position-from-run-count model plus event-based line/frame measurements.
module tb_vga_timing_gen;

  // Instance tables: 0 = 800x600 L2 active-high, 1 = tiny L3 active-high, 2 = tiny L1 active-low.
  localparam int P_HV  [3] = '{800, 16, 20};
  localparam int P_HFP [3] = '{40, 3, 2};
  localparam int P_HS  [3] = '{128, 5, 4};
  localparam int P_HBP [3] = '{88, 4, 6};
  localparam int P_VV  [3] = '{600, 6, 5};
  localparam int P_VFP [3] = '{1, 1, 2};
  localparam int P_VS  [3] = '{4, 2, 3};
  localparam int P_VBP [3] = '{23, 3, 2};
  localparam int P_LAT [3] = '{2, 3, 1};
  localparam int P_POL [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  rgb_in;
  logic [10:0] fx [3];
  logic [9:0]  fy [3];
  logic        fv [3], de [3], hs [3], vs [3], fs [3];
  logic [7:0]  rgb [3];

  int     n_checks = 0;
  int     n_pass = 0;
  longint r = 0;
  longint cyc = 0;
  logic [7:0] prev_rgb;

  longint de_rise0 = -1, hs_rise0 = -1, fs_last1 = -1;
  int     de_len0 = 0, hs_len0 = 0, de_cnt1 = 0;
  logic   de_prev0 = 1'b0, hs_prev0 = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_VIS(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .SYNC_POL(1'b1), .LATENCY(2), .RGB_W(8)
  ) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .fetch_x(fx[0]), .fetch_y(fy[0]), .fetch_valid(fv[0]), .rgb_in(rgb_in),
    .rgb_out(rgb[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .H_VIS(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .LATENCY(3), .RGB_W(8)
  ) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .fetch_x(fx[1]), .fetch_y(fy[1]), .fetch_valid(fv[1]), .rgb_in(rgb_in),
    .rgb_out(rgb[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .H_VIS(20), .H_FP(2), .H_SYNC(4), .H_BP(6),
    .V_VIS(5), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .SYNC_POL(1'b0), .LATENCY(1), .RGB_W(8)
  ) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .fetch_x(fx[2]), .fetch_y(fy[2]), .fetch_valid(fv[2]), .rgb_in(rgb_in),
    .rgb_out(rgb[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .frame_start(fs[2])
  );

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", tag, k, cyc, obs, exp);
    end
  endtask

  function automatic int htot(input int k);
    return P_HV[k] + P_HFP[k] + P_HS[k] + P_HBP[k];
  endfunction

  function automatic int vtot(input int k);
    return P_VV[k] + P_VFP[k] + P_VS[k] + P_VBP[k];
  endfunction

  // Pins after `rr` running edges show the raster position reached LATENCY+1 edges earlier.
  function automatic logic [3:0] model(input int k, input longint rr);
    longint p;
    int h, v;
    logic pol, de_e, hs_a, vs_a, fs_e;
    pol = P_POL[k] != 0;
    if (rr < longint'(P_LAT[k] + 1)) return {1'b0, ~pol, ~pol, 1'b0};
    p = (rr - P_LAT[k] - 1) % longint'(htot(k) * vtot(k));
    h = int'(p % htot(k));
    v = int'(p / htot(k));
    de_e = (h < P_HV[k]) && (v < P_VV[k]);
    hs_a = (h >= P_HV[k] + P_HFP[k]) && (h < P_HV[k] + P_HFP[k] + P_HS[k]);
    vs_a = (v >= P_VV[k] + P_VFP[k]) && (v < P_VV[k] + P_VFP[k] + P_VS[k]);
    fs_e = (h == 0) && (v == 0);
    return {de_e, hs_a ? pol : ~pol, vs_a ? pol : ~pol, fs_e};
  endfunction

  task automatic step();
    logic [3:0] e;
    longint p;
    int h, v;
    logic ve, clr_e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      p = r % longint'(htot(k) * vtot(k));
      h = int'(p % htot(k));
      v = int'(p / htot(k));
      ve = !reset && enable && (h < P_HV[k]) && (v < P_VV[k]);
      check("fetch_valid", k, 32'(fv[k]), 32'(ve));
      if (ve) begin
        check("fetch_x", k, 32'(fx[k]), 32'(h));
        check("fetch_y", k, 32'(fy[k]), 32'(v));
      end
    end
    prev_rgb = rgb_in;
    clr_e = reset || !enable;
    @(posedge clk);
    r = clr_e ? 0 : r + 1;
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      e = model(k, r);
      check("de", k, 32'(de[k]), 32'(e[3]));
      check("hsync", k, 32'(hs[k]), 32'(e[2]));
      check("vsync", k, 32'(vs[k]), 32'(e[1]));
      check("frame_start", k, 32'(fs[k]), 32'(e[0]));
      check("rgb_out", k, 32'(rgb[k]), e[3] ? 32'(prev_rgb) : 32'd0);
    end
    if (clr_e) begin
      de_rise0 = -1; hs_rise0 = -1; fs_last1 = -1;
      de_prev0 = 1'b0; hs_prev0 = 1'b0; de_cnt1 = 0;
    end else begin
      if (de[0] && !de_prev0) begin
        if (de_rise0 >= 0) check("line_period", 0, 32'(cyc - de_rise0), 32'd1056);
        de_rise0 = cyc;
        de_len0 = 0;
      end
      if (de[0]) de_len0++;
      if (!de[0] && de_prev0 && de_rise0 >= 0) check("de_len", 0, 32'(de_len0), 32'd800);
      if (hs[0] && !hs_prev0 && de_rise0 >= 0) begin
        check("hs_offset", 0, 32'(cyc - de_rise0), 32'd840);
        hs_rise0 = cyc;
        hs_len0 = 0;
      end
      if (hs[0]) hs_len0++;
      if (!hs[0] && hs_prev0 && hs_rise0 >= 0) check("hs_len", 0, 32'(hs_len0), 32'd128);
      if (fs[1]) begin
        if (fs_last1 >= 0) begin
          check("frame_period", 1, 32'(cyc - fs_last1), 32'd336);
          check("de_per_frame", 1, 32'(de_cnt1), 32'd96);
        end
        fs_last1 = cyc;
        de_cnt1 = 0;
      end
      if (de[1]) de_cnt1++;
      de_prev0 = de[0];
      hs_prev0 = hs[0];
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    rgb_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) step();

    // Release reset: first visible pixel reaches the pins LATENCY+1 clocks later.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rgb_in = 8'($urandom);
      step();
    end
    check("first_fs", 0, 32'(fs[0]), 32'd1);
    check("first_de", 0, 32'(de[0]), 32'd1);
    for (int i = 0; i < 2400; i++) begin
      rgb_in = 8'($urandom);
      step();
    end

    // Lose lock mid-line at h=400 for 5 clocks.
    for (int i = 0; i < 2000 && (r % 1056) != 400; i++) begin
      rgb_in = 8'($urandom);
      step();
    end
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      rgb_in = 8'($urandom);
      step();
    end

    // Constant white input must still blank outside the active area.
    rgb_in = 8'hFF;
    repeat (1200) step();

    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 149) != 0);
      rgb_in = 8'($urandom);
      step();
    end

    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3500; i++) begin
      rgb_in = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
